uart_bram_loader: RTL

Receives a raw image over UART (8N1, LSB first) and writes it into a left/right frame-buffer BRAM through that BRAM's write port. Each group of BRAM_WIDTH/8 received bytes (6 pixels at the default width) is packed into one BRAM word. The block is the receive-side counterpart of the existing bram_readout UART transmitter, and lets new stereo pairs be loaded without re-synthesising the .mem init files. One instance is used per frame buffer; the stereo FSM waits for done_out before it asserts new_frame_in.

---
 rtl/uart_bram_loader.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/uart_bram_loader.sv
// UART (8N1, LSB first) receiver that packs BRAM_WIDTH/8 bytes per word and
// streams a full frame into a frame-buffer BRAM write port.
module uart_bram_loader #(
    parameter int BRAM_WIDTH = 48,
    parameter int BRAM_DEPTH = 12800,
    parameter int BAUD_RATE  = 3000000,
    parameter int CLK_FREQ   = 100000000
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          uart_rxd,
    input  logic                          enable_in,
    output logic [$clog2(BRAM_DEPTH)-1:0] bram_addr_out,
    output logic [BRAM_WIDTH-1:0]         bram_din_out,
    output logic                          bram_we_out,
    output logic                          done_out,
    output logic                          frame_err_out
);

    localparam int BYTES_PER_WORD = BRAM_WIDTH / 8;
    localparam int CLKS_PER_BIT   = CLK_FREQ / BAUD_RATE;
    localparam int HALF_BIT       = CLKS_PER_BIT / 2;
    localparam int ADDR_W         = $clog2(BRAM_DEPTH);
    localparam int CNT_W          = $clog2(CLKS_PER_BIT + 1);
    localparam int IDX_W          = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

    rx_state_t             state, state_next;
    logic                  rxd_meta, rxd_s;
    logic [CNT_W-1:0]      cnt;
    logic [2:0]            bit_idx;
    logic [7:0]            shift;
    logic                  cnt_clr, bit_take, byte_done, byte_bad;

    logic [IDX_W-1:0]      byte_idx;
    logic [ADDR_W-1:0]     addr_cnt;
    logic [BRAM_WIDTH-1:0] word_reg, word_next;
    logic                  we_q, accept;

    // Both synchronizer flops idle high so reset never looks like a start bit.
    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
        end else begin
            rxd_meta <= uart_rxd;
            rxd_s    <= rxd_meta;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_clr ? '0 : cnt + 1'b1;
            if (bit_take) begin
                shift[bit_idx] <= rxd_s;
                bit_idx        <= bit_idx + 1'b1;
            end else if (state != DATA) begin
                bit_idx <= '0;
            end
        end
    end

    // NOTE: every signal gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        cnt_clr    = 1'b0;
        bit_take   = 1'b0;
        byte_done  = 1'b0;
        byte_bad   = 1'b0;
        if (!enable_in) begin
            state_next = IDLE;
            cnt_clr    = 1'b1;
        end else begin
            case (state)
                IDLE: if (!done_out && !rxd_s) begin
                    state_next = START;
                    cnt_clr    = 1'b1;
                end
                START: if (cnt == CNT_W'(HALF_BIT)) begin
                    cnt_clr    = 1'b1;
                    state_next = rxd_s ? IDLE : DATA;
                end
                DATA: if (cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                    cnt_clr  = 1'b1;
                    bit_take = 1'b1;
                    if (bit_idx == 3'd7) state_next = STOP;
                end
                STOP: if (cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                    cnt_clr    = 1'b1;
                    state_next = IDLE;
                    byte_done  = rxd_s;
                    byte_bad   = !rxd_s;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        word_next = word_reg;
        word_next[8*int'(byte_idx) +: 8] = shift;
    end

    assign accept = byte_done && !done_out;

    // A strobe already registered is still killed by a same-cycle abort or reset.
    assign bram_we_out = we_q && enable_in && !rst_in;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            byte_idx      <= '0;
            addr_cnt      <= '0;
            word_reg      <= '0;
            we_q          <= 1'b0;
            bram_din_out  <= '0;
            bram_addr_out <= '0;
            done_out      <= 1'b0;
            frame_err_out <= 1'b0;
        end else if (!enable_in) begin
            byte_idx      <= '0;
            addr_cnt      <= '0;
            word_reg      <= '0;
            we_q          <= 1'b0;
            done_out      <= 1'b0;
            frame_err_out <= 1'b0;
        end else begin
            we_q <= 1'b0;
            if (byte_bad && !done_out) frame_err_out <= 1'b1;
            if (accept) begin
                word_reg <= word_next;
                if (byte_idx == IDX_W'(BYTES_PER_WORD - 1)) begin
                    byte_idx      <= '0;
                    we_q          <= 1'b1;
                    bram_din_out  <= word_next;
                    bram_addr_out <= addr_cnt;
                end else begin
                    byte_idx <= byte_idx + 1'b1;
                end
            end
            if (we_q) begin
                if (addr_cnt == ADDR_W'(BRAM_DEPTH - 1)) done_out <= 1'b1;
                else                                      addr_cnt <= addr_cnt + 1'b1;
            end
        end
    end

endmodule
